// File: rtl/p2l_multi.sv
// ---------------------------------------------------------------------------
// p2l_multi : N-channel pulse-to-level launcher, source side of a CDC
//             pulse crossing.
//
// Each single-cycle pulse on in[i] produces one toggle of out[i]. The
// destination domain returns the toggle on ack[i]. That acknowledge is
// resynchronised into clk1. While a request is in flight, new pulses are
// queued in a per-channel saturating counter. They are not lost.
//
// Parameters
//   NCH          number of independent channels
//   CNT_W        width of per-channel pending counter (max queued 2^CNT_W-1)
//   SYNC_STAGES  synchroniser depth on each ack bit (>= 2)
//
// Ports
//   clk1     source-domain clock
//   reset    asynchronous reset, active-low
//   in       single-cycle pulse per channel (clk1 domain)
//   ack      toggle acknowledge from the destination domain (asynchronous)
//   ovf_clr  clears the sticky overflow flag per channel
//   out      registered toggle level per channel
//   busy     request in flight or pulses pending
//   ovf      sticky: a pulse was dropped on a saturated counter
//   pend     pending count, channel i at [i*CNT_W +: CNT_W]
//   err      (P2L_PROTO_ERR_EN only) sticky: ack changed while channel idle
//
// Build option
//   P2L_PROTO_ERR_EN  adds the err output. Without it, a spurious ack seen
//                     while IDLE is silently ignored.
// ---------------------------------------------------------------------------
module p2l_multi #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk1,
  input  logic                 reset,
  input  logic [NCH-1:0]       in,
  input  logic [NCH-1:0]       ack,
  input  logic [NCH-1:0]       ovf_clr,
  output logic [NCH-1:0]       out,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       ovf,
`ifdef P2L_PROTO_ERR_EN
  output logic [NCH-1:0]       err,
`endif
  output logic [NCH*CNT_W-1:0] pend
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Queue one more pulse while waiting. A full counter holds its value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // The launch consumes one entry, and a same-cycle pulse adds one back.
  // A launch only happens when c != 0 or p == 1, so this cannot underflow.
  function automatic logic [CNT_W-1:0] launch_cnt(input logic [CNT_W-1:0] c,
                                                  input logic             p);
    return p ? c : c - CNT_ONE;
  endfunction

  // ack synchroniser: ack_sync[0] sees the asynchronous input
  logic [NCH-1:0] ack_sync [SYNC_STAGES];
  logic [NCH-1:0] ack_s;

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) ack_sync[s] <= '0;
    end else begin
      ack_sync[0] <= ack;
      for (int s = 1; s < SYNC_STAGES; s++) ack_sync[s] <= ack_sync[s-1];
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

`ifdef P2L_PROTO_ERR_EN
  // Previous synchronised ack, used to spot an ack edge arriving while idle
  logic [NCH-1:0] ack_s_d;
  logic [NCH-1:0] ack_chg;

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) ack_s_d <= '0;
    else        ack_s_d <= ack_s;
  end

  assign ack_chg = ack_s ^ ack_s_d;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic             st;
    logic             tog;
    logic [CNT_W-1:0] cnt;
    logic             ov;
    logic             launch;
    logic             drop;
    logic             done;

    assign launch = (st == ST_IDLE) && (in[i] || (cnt != '0));
    assign drop   = (st == ST_WAIT) && in[i] && (cnt == CNT_MAX);
    assign done   = (st == ST_WAIT) && (ack_s[i] == tog);

    always_ff @(posedge clk1 or negedge reset) begin
      if (!reset) begin
        st  <= ST_IDLE;
        tog <= 1'b0;
        cnt <= '0;
        ov  <= 1'b0;
      end else begin
        if (st == ST_IDLE) begin
          // ack_s is not examined here, so a spurious ack while idle is ignored
          if (launch) begin
            tog <= ~tog;
            st  <= ST_WAIT;
            cnt <= launch_cnt(cnt, in[i]);
          end
        end else begin
          if (in[i]) cnt <= sat_inc(cnt);
          if (done)  st  <= ST_IDLE;
        end
        // a drop in the same cycle as a clear wins, so the loss stays visible
        if (drop)            ov <= 1'b1;
        else if (ovf_clr[i]) ov <= 1'b0;
      end
    end

    assign out[i]                  = tog;
    assign busy[i]                 = (st == ST_WAIT) || (cnt != '0);
    assign ovf[i]                  = ov;
    assign pend[i*CNT_W +: CNT_W]  = cnt;

`ifdef P2L_PROTO_ERR_EN
    logic er;

    always_ff @(posedge clk1 or negedge reset) begin
      if (!reset)                             er <= 1'b0;
      else if ((st == ST_IDLE) && ack_chg[i]) er <= 1'b1;
      else if (ovf_clr[i])                    er <= 1'b0;
    end

    assign err[i] = er;
`endif
  end

endmodule

// File: tb/tb_p2l_multi.sv
// ---------------------------------------------------------------------------
// tb_p2l_multi : scoreboard bench for p2l_multi (NCH=4, CNT_W=2,
// SYNC_STAGES=2).
// Stimulus pushes expected output values, tagged with the clk1 edge after
// which they must hold, into a queue. A monitor on the falling edge pops
// every entry that is due and compares it against the DUT outputs. The
// monitor also counts the toggles seen on out.
// ---------------------------------------------------------------------------
module tb_p2l_multi;
  localparam int NCH = 4;
  localparam int CNT_W = 2;
  localparam int SS = 2;

  logic       clk1 = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] in = '0;
  logic [3:0] ack;
  logic [3:0] ovf_clr = '0;
  logic [3:0] out;
  logic [3:0] busy;
  logic [3:0] ovf;
  logic [7:0] pend;
`ifdef P2L_PROTO_ERR_EN
  logic [3:0] err;
`endif

  p2l_multi #(.NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
    .clk1    (clk1),
    .reset   (reset),
    .in      (in),
    .ack     (ack),
    .ovf_clr (ovf_clr),
    .out     (out),
    .busy    (busy),
    .ovf     (ovf),
`ifdef P2L_PROTO_ERR_EN
    .err     (err),
`endif
    .pend    (pend)
  );

  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  // Destination-side ack model: hold value, or out delayed by ack_dly cycles
  logic [3:0]  ack_hold = '0;
  logic [3:0]  ack_mode = '0;
  int          ack_dly [4] = '{0, 0, 0, 0};
  logic [15:0] hist [4] = '{default: '0};

  always @(posedge clk1)
    for (int i = 0; i < 4; i++) hist[i] <= {hist[i][14:0], out[i]};

  always_comb begin
    ack = '0;
    for (int i = 0; i < 4; i++)
      ack[i] = ack_mode[i] ? ((ack_dly[i] == 0) ? out[i] : hist[i][ack_dly[i]-1])
                           : ack_hold[i];
  end

  // Scoreboard. sig: 0 out, 1 busy, 2 pend, 3 ovf, 4 toggle count of ch
  typedef struct {
    int          at;
    string       nm;
    int          sig;
    int          ch;
    logic [31:0] ev;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int tcount [4] = '{0, 0, 0, 0};
  logic [3:0] prev_out = '0;

  function automatic logic [31:0] actual(int sig, int ch);
    case (sig)
      0:       return {28'b0, out};
      1:       return {28'b0, busy};
      2:       return {24'b0, pend};
      3:       return {28'b0, ovf};
      default: return tcount[ch];
    endcase
  endfunction

  always @(negedge clk1) begin
    logic [31:0] act;
    for (int i = 0; i < 4; i++) if (out[i] !== prev_out[i]) tcount[i]++;
    prev_out = out;
    for (int j = q.size() - 1; j >= 0; j--) begin
      if (q[j].at <= cyc) begin
        act = actual(q[j].sig, q[j].ch);
        checks++;
        if (q[j].at < cyc) begin
          errors++;
          $display("FAIL %s: due at edge %0d, not checked (now %0d)", q[j].nm, q[j].at, cyc);
        end else if (act !== q[j].ev) begin
          errors++;
          $display("FAIL %s @edge %0d: got %0h, expected %0h", q[j].nm, cyc, act, q[j].ev);
        end
        q.delete(j);
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic expect_at(int at, string nm, int sig, int ch, logic [31:0] v);
    q.push_back('{at, nm, sig, ch, v});
  endtask

  task automatic exp_all(int at, string tag, logic [3:0] o, logic [3:0] b,
                         logic [7:0] p, logic [3:0] f);
    expect_at(at, {tag, "_out"},  0, 0, {28'b0, o});
    expect_at(at, {tag, "_busy"}, 1, 0, {28'b0, b});
    expect_at(at, {tag, "_pend"}, 2, 0, {24'b0, p});
    expect_at(at, {tag, "_ovf"},  3, 0, {28'b0, f});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, b, o, s0, t0;

    // Reset held with all inputs pulsing and ack toggling
    reset = 1'b0;
    in = 4'hF;
    ack_hold = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_all(cyc, "rst", 4'h0, 4'h0, 8'h00, 4'h0);
      ack_hold = ~ack_hold;
    end
    ack_hold = '0;
    in = '0;
    reset = 1'b1;
    exp_all(cyc + 2, "post_rst", 4'h0, 4'h0, 8'h00, 4'h0);
    tick();
    tick();

    // ch0 and ch1 loop back with zero delay. ch2 and ch3 hold ack at 0.
    ack_mode = 4'b0011;

    // Single pulse on ch0
    k = cyc + 1;
    exp_all(k, "single_k", 4'b0001, 4'b0001, 8'h00, 4'h0);
    expect_at(k + 2, "single_busy_k2", 1, 0, 4'b0001);
    exp_all(k + 3, "single_k3", 4'b0001, 4'b0000, 8'h00, 4'h0);
    in = 4'b0001;
    tick();
    in = '0;
    repeat (8) tick();

    // Burst of four pulses on ch1
    b = cyc + 1;
    exp_all(b + 3,  "burst_peak", 4'b0011, 4'b0010, 8'h0C, 4'h0);
    exp_all(b + 4,  "burst_l2",   4'b0001, 4'b0010, 8'h08, 4'h0);
    exp_all(b + 8,  "burst_l3",   4'b0011, 4'b0010, 8'h04, 4'h0);
    exp_all(b + 12, "burst_l4",   4'b0001, 4'b0010, 8'h00, 4'h0);
    exp_all(b + 16, "burst_end",  4'b0001, 4'b0000, 8'h00, 4'h0);
    expect_at(b + 16, "burst_toggles_ch1", 4, 1, 32'd4);
    for (int i = 0; i < 4; i++) begin
      in = 4'b0010;
      tick();
    end
    in = '0;
    repeat (20) tick();

    // Overflow on ch2: ack never returns
    o = cyc + 1;
    exp_all(o + 3, "ovf_full",    4'b0101, 4'b0100, 8'h30, 4'b0000);
    exp_all(o + 4, "ovf_drop",    4'b0101, 4'b0100, 8'h30, 4'b0100);
    exp_all(o + 5, "ovf_clr",     4'b0101, 4'b0100, 8'h30, 4'b0000);
    expect_at(o + 6, "ovf_set_wins", 3, 0, 4'b0100);
    expect_at(o + 7, "ovf_reclr",    3, 0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      in = 4'b0100;
      tick();
    end
    in = '0;
    ovf_clr = 4'b0100;
    tick();
    in = 4'b0100;
    tick();
    in = '0;
    tick();
    ovf_clr = '0;
    ack_mode[2] = 1'b1;
    repeat (30) tick();
    exp_all(cyc + 1, "ovf_drain", 4'b0001, 4'b0000, 8'h00, 4'h0);
    expect_at(cyc + 1, "ovf_toggles_ch2", 4, 2, 32'd4);
    tick();

    // ch3: a pulse arrives at the same edge as the matching ack, with pend=2
    s0 = cyc + 1;
    exp_all(s0 + 2, "sim_pend2", 4'b1001, 4'b1000, 8'h80, 4'h0);
    expect_at(s0 + 4, "sim_wait_pend", 2, 0, 8'h80);
    exp_all(s0 + 5, "sim_idle",   4'b1001, 4'b1000, 8'hC0, 4'h0);
    exp_all(s0 + 6, "sim_launch", 4'b0001, 4'b1000, 8'h80, 4'h0);
    for (int i = 0; i < 3; i++) begin
      in = 4'b1000;
      tick();
    end
    in = '0;
    ack_hold[3] = 1'b1;
    tick();
    tick();
    in = 4'b1000;
    tick();
    in = '0;
    tick();
    ack_mode[3] = 1'b1;
    repeat (30) tick();
    exp_all(cyc + 1, "sim_drain", 4'b0001, 4'b0000, 8'h00, 4'h0);
    expect_at(cyc + 1, "sim_toggles_ch3", 4, 3, 32'd4);
    tick();

    // All channels, ack delays 0/3/7/12, pulse counts 1/2/3/4
    ack_dly = '{0, 3, 7, 12};
    ack_mode = 4'hF;
    t0 = cyc + 1;
    expect_at(t0 + 3, "ind_out",  0, 0, 4'b1110);
    expect_at(t0 + 3, "ind_busy", 1, 0, 4'b1110);
    expect_at(t0 + 3, "ind_pend", 2, 0, 8'hE4);
    in = 4'hF; tick();
    in = 4'hE; tick();
    in = 4'hC; tick();
    in = 4'h8; tick();
    in = '0;
    repeat (250) tick();
    exp_all(cyc + 1, "ind_end", 4'b0100, 4'b0000, 8'h00, 4'h0);
    expect_at(cyc + 1, "ind_toggles_ch0", 4, 0, 32'd2);
    expect_at(cyc + 1, "ind_toggles_ch1", 4, 1, 32'd6);
    expect_at(cyc + 1, "ind_toggles_ch2", 4, 2, 32'd7);
    expect_at(cyc + 1, "ind_toggles_ch3", 4, 3, 32'd8);
    tick();
    repeat (3) tick();

    while (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation for edge %0d never checked", q[0].nm, q[0].at);
      void'(q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
